// File: rtl/monitor_uart_pkg.sv
// Shared types and constants for the 68000-bus UART transmit FIFO.
// Status register layout and the drain busy-timeout length live here.
package monitor_uart_pkg;

   typedef enum logic {
      B_IDLE,
      B_ACK
   } bus_state_e;

   typedef enum logic [1:0] {
      D_IDLE,
      D_PULSE,
      D_WAIT_BUSY,
      D_WAIT_IDLE
   } drain_state_e;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVERFLOW  = 2;
   localparam int ST_COUNT_LSB = 8;
   localparam int ST_COUNT_MSB = 15;

   localparam logic [7:0] BUSY_TIMEOUT = 8'd255;

   function automatic logic [15:0] status_word(input logic [7:0] cnt,
                                               input logic       ovf,
                                               input logic       full,
                                               input logic       empty);
      logic [15:0] w;
      w                            = '0;
      w[ST_COUNT_MSB:ST_COUNT_LSB] = cnt;
      w[ST_OVERFLOW]               = ovf;
      w[ST_FULL]                   = full;
      w[ST_EMPTY]                  = empty;
      return w;
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO of 2^DEPTH_LOG2 entries with a registered head byte.
// Pushes to a full FIFO are ignored; the full test uses the pre-pop count.
module uart_byte_fifo
   import monitor_uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic [7:0]            wdata_i,
   input  logic                  pop_i,
   output logic [7:0]            head_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [7:0]            head_q;
   logic                  do_push, do_pop;

   assign full_o  = count_q[DEPTH_LOG2];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = head_q;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rd_nxt  = rd_ptr_q + 1'b1;
   assign count_d = count_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_nxt;
         count_q <= count_d;
         // Incoming byte becomes head when nothing older remains behind it.
         if (do_push && (empty_o || (do_pop && count_q == (DEPTH_LOG2+1)'(1))))
            head_q <= wdata_i;
         else if (do_pop)
            head_q <= mem_q[rd_nxt];
      end
   end

endmodule

// File: rtl/monitor_uart_fifo.sv
// 68000-bus UART transmit peripheral: CPU writes fill a FIFO drained into the monitor mailbox.
// Optional macro UART_FIFO_BUSY_TIMEOUT_EN abandons a handshake whose busy never rises.
module monitor_uart_fifo
   import monitor_uart_pkg::*;
#(
   parameter int DEPTH_LOG2    = 4,
   parameter int TRIGGER_WIDTH = 2
) (
   input  logic        MCLK_IN,
   input  logic        RUN_IN,
   input  logic        CS_IN,
   input  logic        AS_IN,
   input  logic        RW_IN,
   input  logic        LDS_IN,
   input  logic        REG_ADDR_IN,
   input  logic [7:0]  DATA_IN,
   output logic [15:0] DATA_OUT,
   output logic        DATA_OE,
   output logic        DTACK,
   input  logic        UART_SEND_BUSY_IN,
   output logic        UART_SEND_TRIGGER,
   output logic [7:0]  UART_SEND_BYTE
);

   localparam int PW = $clog2(TRIGGER_WIDTH + 1);

   logic                strb_s1_q, strb_s2_q, busy_s1_q, busy_s2_q;
   bus_state_e          bus_q;
   logic                dtack_q, oe_q, ovf_q;
   logic [15:0]         dout_q;
   drain_state_e        drn_q;
   logic                trig_q;
   logic [7:0]          byte_q;
   logic [PW-1:0]       pcnt_q;
`ifdef UART_FIFO_BUSY_TIMEOUT_EN
   logic [7:0]          tmo_q;
`endif

   logic                wr_data, pop;
   logic [7:0]          head;
   logic [DEPTH_LOG2:0] count;
   logic                full, empty;

   assign DATA_OUT          = dout_q;
   assign DATA_OE           = oe_q;
   assign DTACK             = dtack_q;
   assign UART_SEND_TRIGGER = trig_q;
   assign UART_SEND_BYTE    = byte_q;

   always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
      if (!RUN_IN) begin
         strb_s1_q <= 1'b1;
         strb_s2_q <= 1'b1;
         busy_s1_q <= 1'b0;
         busy_s2_q <= 1'b0;
      end else begin
         strb_s1_q <= AS_IN | CS_IN;
         strb_s2_q <= strb_s1_q;
         busy_s1_q <= UART_SEND_BUSY_IN;
         busy_s2_q <= busy_s1_q;
      end
   end

   assign wr_data = (bus_q == B_IDLE) && !strb_s2_q && !RW_IN && !LDS_IN && !REG_ADDR_IN;
   assign pop     = (drn_q == D_IDLE) && !empty && !busy_s2_q;

   uart_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk_i   (MCLK_IN),
      .rst_ni  (RUN_IN),
      .push_i  (wr_data),
      .wdata_i (DATA_IN),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
      if (!RUN_IN) begin
         bus_q   <= B_IDLE;
         dtack_q <= 1'b1;
         oe_q    <= 1'b0;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (bus_q)
            B_IDLE: if (!strb_s2_q) begin
               dtack_q <= 1'b0;
               bus_q   <= B_ACK;
               if (RW_IN) begin
                  oe_q <= 1'b1;
                  if (REG_ADDR_IN) begin
                     dout_q <= status_word(8'(count), ovf_q, full, empty);
                     ovf_q  <= 1'b0;
                  end else begin
                     dout_q <= '0;
                  end
               end else if (wr_data && full) begin
                  ovf_q <= 1'b1;
               end
            end
            B_ACK: if (strb_s2_q) begin
               dtack_q <= 1'b1;
               oe_q    <= 1'b0;
               bus_q   <= B_IDLE;
            end
            default: bus_q <= B_IDLE;
         endcase
      end
   end

   always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
      if (!RUN_IN) begin
         drn_q  <= D_IDLE;
         trig_q <= 1'b0;
         byte_q <= '0;
         pcnt_q <= '0;
`ifdef UART_FIFO_BUSY_TIMEOUT_EN
         tmo_q  <= '0;
`endif
      end else begin
         case (drn_q)
            D_IDLE: if (pop) begin
               byte_q <= head;
               drn_q  <= D_PULSE;
            end
            // First cycle in D_PULSE raises the trigger, so the byte is stable a cycle ahead.
            D_PULSE: if (!trig_q) begin
               trig_q <= 1'b1;
               pcnt_q <= PW'(1);
            end else if (pcnt_q == PW'(TRIGGER_WIDTH)) begin
               trig_q <= 1'b0;
               drn_q  <= D_WAIT_BUSY;
`ifdef UART_FIFO_BUSY_TIMEOUT_EN
               tmo_q  <= '0;
`endif
            end else begin
               pcnt_q <= pcnt_q + 1'b1;
            end
            D_WAIT_BUSY: begin
               if (busy_s2_q) drn_q <= D_WAIT_IDLE;
`ifdef UART_FIFO_BUSY_TIMEOUT_EN
               else if (tmo_q == BUSY_TIMEOUT - 8'd1) drn_q <= D_IDLE;
               else tmo_q <= tmo_q + 8'd1;
`endif
            end
            D_WAIT_IDLE: if (!busy_s2_q) drn_q <= D_IDLE;
            default: drn_q <= D_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_monitor_uart_fifo.sv
// Scoreboard bench for monitor_uart_fifo: bytes written are queued and checked at each trigger.
module tb_monitor_uart_fifo;

   localparam int DL = 4;
   localparam int TW = 2;

   logic        MCLK_IN = 1'b0;
   logic        RUN_IN, CS_IN, AS_IN, RW_IN, LDS_IN, REG_ADDR_IN;
   logic [7:0]  DATA_IN;
   logic [15:0] DATA_OUT;
   logic        DATA_OE, DTACK;
   logic        UART_SEND_BUSY_IN;
   logic        UART_SEND_TRIGGER;
   logic [7:0]  UART_SEND_BYTE;

   logic busy_force = 1'b0;
   logic busy_model = 1'b0;
   logic auto_en    = 1'b0;
   assign UART_SEND_BUSY_IN = busy_force | busy_model;

   int n_cmp = 0, n_err = 0;
   int n_trig = 0, cyc = 0, rise_cyc = 0, fall_cyc = 0, min_gap = 9999;
   logic [7:0] exp_q[$];

   monitor_uart_fifo #(.DEPTH_LOG2(DL), .TRIGGER_WIDTH(TW)) dut (
      .MCLK_IN           (MCLK_IN),
      .RUN_IN            (RUN_IN),
      .CS_IN             (CS_IN),
      .AS_IN             (AS_IN),
      .RW_IN             (RW_IN),
      .LDS_IN            (LDS_IN),
      .REG_ADDR_IN       (REG_ADDR_IN),
      .DATA_IN           (DATA_IN),
      .DATA_OUT          (DATA_OUT),
      .DATA_OE           (DATA_OE),
      .DTACK             (DTACK),
      .UART_SEND_BUSY_IN (UART_SEND_BUSY_IN),
      .UART_SEND_TRIGGER (UART_SEND_TRIGGER),
      .UART_SEND_BYTE    (UART_SEND_BYTE)
   );

   always #5 MCLK_IN = ~MCLK_IN;

   // Trigger monitor: pops the scoreboard on each rising edge, checks pulse width.
   initial begin
      logic       prev;
      logic [7:0] e;
      int         w;
      prev = 1'b0;
      w    = 0;
      forever begin
         @(posedge MCLK_IN); #1;
         cyc++;
         if (UART_SEND_TRIGGER === 1'b1 && !prev) begin
            if (n_trig > 0 && (cyc - rise_cyc) < min_gap) min_gap = cyc - rise_cyc;
            n_trig++;
            rise_cyc = cyc;
            w = 0;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL trig_byte: got %h, scoreboard empty", UART_SEND_BYTE);
            end else begin
               e = exp_q.pop_front();
               if (UART_SEND_BYTE !== e) begin
                  n_err++;
                  $display("FAIL trig_byte: got %h, expected %h", UART_SEND_BYTE, e);
               end
            end
         end
         if (UART_SEND_TRIGGER === 1'b1) w++;
         if (UART_SEND_TRIGGER !== 1'b1 && prev) begin
            fall_cyc = cyc;
            n_cmp++;
            if (w !== TW) begin
               n_err++;
               $display("FAIL trig_width: got %0d cycles, expected %0d", w, TW);
            end
         end
         prev = (UART_SEND_TRIGGER === 1'b1);
      end
   end

   // Monitor busy model: rises 3 cycles after trigger, drops 20 cycles later.
   initial begin
      forever begin
         @(posedge UART_SEND_TRIGGER);
         if (auto_en) begin
            repeat (3) @(posedge MCLK_IN);
            #1 busy_model = 1'b1;
            repeat (20) @(posedge MCLK_IN);
            #1 busy_model = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic bus_access(input logic rw, input logic addr, input logic [7:0] d,
                             input logic rel_busy, output logic [15:0] rdata,
                             output logic oe, output int ack_cyc);
      int t;
      @(posedge MCLK_IN); #1;
      RW_IN = rw; REG_ADDR_IN = addr; LDS_IN = 1'b0; DATA_IN = d;
      CS_IN = 1'b0; AS_IN = 1'b0;
      if (rel_busy) busy_force = 1'b0;
      t = 0;
      while (DTACK !== 1'b0 && t < 20) begin @(negedge MCLK_IN); t++; end
      ack_cyc = cyc;
      rdata = DATA_OUT;
      oe    = DATA_OE;
      n_cmp++;
      if (DTACK !== 1'b0) begin
         n_err++;
         $display("FAIL bus_ack: DTACK %b after %0d cycles, expected 0", DTACK, t);
      end
      @(posedge MCLK_IN); #1;
      CS_IN = 1'b1; AS_IN = 1'b1; LDS_IN = 1'b1; RW_IN = 1'b1;
      t = 0;
      while ((DTACK !== 1'b1 || DATA_OE !== 1'b0) && t < 20) begin @(negedge MCLK_IN); t++; end
      n_cmp++;
      if (DTACK !== 1'b1 || DATA_OE !== 1'b0) begin
         n_err++;
         $display("FAIL bus_release: DTACK %b OE %b, expected 1 0", DTACK, DATA_OE);
      end
   endtask

   task automatic bus_write(input logic [7:0] d, input logic rel_busy, output int ack_cyc);
      logic [15:0] rd;
      logic        oe;
      bus_access(1'b0, 1'b0, d, rel_busy, rd, oe, ack_cyc);
   endtask

   task automatic bus_read(input logic addr, output logic [15:0] rd, output logic oe);
      int a;
      bus_access(1'b1, addr, 8'h00, 1'b0, rd, oe, a);
   endtask

   task automatic wait_drained(input int budget);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < budget) begin @(negedge MCLK_IN); t++; end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d bytes left after %0d cycles, expected 0", exp_q.size(), budget);
      end
   endtask

   task automatic test_reset();
      logic [15:0] rd;
      logic        oe;
      RUN_IN = 1'b0; CS_IN = 1'b1; AS_IN = 1'b1; RW_IN = 1'b1; LDS_IN = 1'b1;
      REG_ADDR_IN = 1'b0; DATA_IN = 8'h00;
      repeat (3) @(negedge MCLK_IN);
      n_cmp += 5;
      if (DTACK !== 1'b1) begin n_err++; $display("FAIL rst_dtack: got %b expected 1", DTACK); end
      if (DATA_OE !== 1'b0) begin n_err++; $display("FAIL rst_oe: got %b expected 0", DATA_OE); end
      if (UART_SEND_TRIGGER !== 1'b0) begin n_err++; $display("FAIL rst_trig: got %b expected 0", UART_SEND_TRIGGER); end
      if (UART_SEND_BYTE !== 8'h00) begin n_err++; $display("FAIL rst_byte: got %h expected 00", UART_SEND_BYTE); end
      if (DATA_OUT !== 16'h0000) begin n_err++; $display("FAIL rst_dout: got %h expected 0000", DATA_OUT); end
      @(posedge MCLK_IN); #1 RUN_IN = 1'b1;
      bus_read(1'b1, rd, oe);
      n_cmp += 2;
      if (rd !== 16'h0001) begin n_err++; $display("FAIL rst_status: got %h expected 0001", rd); end
      if (oe !== 1'b1) begin n_err++; $display("FAIL rst_status_oe: got %b expected 1", oe); end
      bus_read(1'b0, rd, oe);
      n_cmp += 2;
      if (rd !== 16'h0000) begin n_err++; $display("FAIL data_read: got %h expected 0000", rd); end
      if (oe !== 1'b1) begin n_err++; $display("FAIL data_read_oe: got %b expected 1", oe); end
   endtask

   task automatic test_single();
      logic [15:0] rd;
      logic        oe;
      int          ack, base, t;
      auto_en = 1'b1;
      base = n_trig;
      exp_q.push_back(8'h41);
      bus_write(8'h41, 1'b0, ack);
      t = 0;
      while (n_trig == base && t < 50) begin @(negedge MCLK_IN); t++; end
      n_cmp++;
      if (rise_cyc !== ack + 2) begin
         n_err++;
         $display("FAIL single_latency: trigger at cycle %0d, expected %0d", rise_cyc, ack + 2);
      end
      repeat (60) @(negedge MCLK_IN);
      n_cmp += 2;
      if (n_trig !== base + 1) begin n_err++; $display("FAIL single_count: got %0d triggers expected 1", n_trig - base); end
      if (exp_q.size() != 0) begin n_err++; $display("FAIL single_drain: %0d left expected 0", exp_q.size()); end
      bus_read(1'b1, rd, oe);
      n_cmp++;
      if (rd !== 16'h0001) begin n_err++; $display("FAIL single_status: got %h expected 0001", rd); end
   endtask

   task automatic test_burst();
      logic [15:0] rd;
      logic        oe;
      int          ack, base, t;
      busy_force = 1'b1;
      repeat (4) @(negedge MCLK_IN);
      base = n_trig;
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(8'h30 + 8'(i));
         bus_write(8'h30 + 8'(i), 1'b0, ack);
      end
      bus_read(1'b1, rd, oe);
      n_cmp++;
      if (rd !== 16'h1002) begin n_err++; $display("FAIL burst_full: got %h expected 1002", rd); end
      bus_write(8'h99, 1'b0, ack);
      bus_read(1'b1, rd, oe);
      n_cmp++;
      if (rd !== 16'h1006) begin n_err++; $display("FAIL burst_ovf: got %h expected 1006", rd); end
      bus_read(1'b1, rd, oe);
      n_cmp += 2;
      if (rd !== 16'h1002) begin n_err++; $display("FAIL burst_ovf_clr: got %h expected 1002", rd); end
      if (n_trig !== base) begin n_err++; $display("FAIL burst_hold: got %0d triggers while busy, expected 0", n_trig - base); end
      @(posedge MCLK_IN); #1 busy_force = 1'b0;
      t = 0;
      while (n_trig == base && t < 50) begin @(negedge MCLK_IN); t++; end
      min_gap = 9999;
      wait_drained(2000);
      repeat (60) @(negedge MCLK_IN);
      n_cmp += 2;
      if (n_trig !== base + 16) begin n_err++; $display("FAIL burst_count: got %0d triggers expected 16", n_trig - base); end
      if (min_gap !== 28) begin n_err++; $display("FAIL burst_gap: min spacing %0d cycles, expected 28", min_gap); end
      bus_read(1'b1, rd, oe);
      n_cmp++;
      if (rd !== 16'h0001) begin n_err++; $display("FAIL burst_status: got %h expected 0001", rd); end
   endtask

   task automatic test_push_pop_same_edge();
      logic [15:0] rd;
      logic        oe;
      int          ack, base;
      busy_force = 1'b1;
      repeat (4) @(negedge MCLK_IN);
      base = n_trig;
      exp_q.push_back(8'h61); bus_write(8'h61, 1'b0, ack);
      exp_q.push_back(8'h62); bus_write(8'h62, 1'b0, ack);
      // Busy release and strobe share a timestep, so pop and push land on one edge.
      exp_q.push_back(8'h63); bus_write(8'h63, 1'b1, ack);
      bus_read(1'b1, rd, oe);
      n_cmp++;
      if (rd !== 16'h0200) begin n_err++; $display("FAIL same_edge_count: got %h expected 0200", rd); end
      wait_drained(500);
      repeat (60) @(negedge MCLK_IN);
      n_cmp++;
      if (n_trig !== base + 3) begin n_err++; $display("FAIL same_edge_trigs: got %0d expected 3", n_trig - base); end
      bus_read(1'b1, rd, oe);
      n_cmp++;
      if (rd !== 16'h0001) begin n_err++; $display("FAIL same_edge_status: got %h expected 0001", rd); end
   endtask

   task automatic test_busy_timeout();
      logic [15:0] rd;
      logic        oe;
      int          ack, base, t, f1;
      auto_en = 1'b0;
      busy_force = 1'b0;
      base = n_trig;
      exp_q.push_back(8'h55); bus_write(8'h55, 1'b0, ack);
      exp_q.push_back(8'h56); bus_write(8'h56, 1'b0, ack);
      t = 0;
      while (n_trig == base && t < 50) begin @(negedge MCLK_IN); t++; end
      repeat (5) @(negedge MCLK_IN);
      f1 = fall_cyc;
      t = 0;
      while (n_trig < base + 2 && t < 400) begin @(negedge MCLK_IN); t++; end
`ifdef UART_FIFO_BUSY_TIMEOUT_EN
      n_cmp += 2;
      if (n_trig !== base + 2) begin n_err++; $display("FAIL tmo_retrigger: got %0d triggers expected 2", n_trig - base); end
      if (rise_cyc - f1 !== 257) begin n_err++; $display("FAIL tmo_delay: got %0d cycles expected 257", rise_cyc - f1); end
      repeat (10) @(negedge MCLK_IN);
      bus_read(1'b1, rd, oe);
      n_cmp++;
      if (rd !== 16'h0001) begin n_err++; $display("FAIL tmo_status: got %h expected 0001", rd); end
`else
      n_cmp += 2;
      if (n_trig !== base + 1) begin n_err++; $display("FAIL nobusy_hold: got %0d triggers expected 1", n_trig - base); end
      if (exp_q.size() != 1) begin n_err++; $display("FAIL nobusy_queue: %0d pending expected 1", exp_q.size()); end
      bus_read(1'b1, rd, oe);
      n_cmp++;
      if (rd !== 16'h0100) begin n_err++; $display("FAIL nobusy_status: got %h expected 0100 (f1=%0d)", rd, f1); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_push_pop_same_edge();
      test_busy_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/monitor_uart_fifo.md
# monitor_uart_fifo

- 68000-bus UART transmit peripheral, upstream of the monitor SPI bridge.
- Buffers bytes the CPU writes to a memory-mapped data register in a small FIFO.
- Drains the FIFO one byte at a time into the monitor's single-byte UART mailbox. Each transfer drives UART_SEND_BYTE, raises UART_SEND_TRIGGER, then waits for the busy handshake.
- Exposes a status register so firmware can poll fill level and overflow.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 bytes.
- TRIGGER_WIDTH, 2: UART_SEND_TRIGGER high time in MCLK cycles (≥1).

Ports:
- MCLK_IN  in  1  system clock, all state on rising edge.
- RUN_IN  in  1  asynchronous active-low reset.
- CS_IN  in  1  active-low decoded chip select.
- AS_IN  in  1  active-low 68000 address strobe.
- RW_IN  in  1  1 = read, 0 = write.
- LDS_IN  in  1  active-low lower data strobe.
- REG_ADDR_IN  in  1  A1: 0 = data register, 1 = status register.
- DATA_IN  in  8  D7:D0 write data.
- DATA_OUT  out  16  read data.
- DATA_OE  out  1  high while DATA_OUT must drive the bus.
- DTACK  out  1  active-low transfer acknowledge.
- UART_SEND_BUSY_IN  in  1  monitor busy flag (asynchronous to MCLK).
- UART_SEND_TRIGGER  out  1  rising edge hands UART_SEND_BYTE to the monitor.
- UART_SEND_BYTE  out  8  byte presented to the monitor.

## Operation
- Reset values: DTACK=1, DATA_OE=0, DATA_OUT=0, UART_SEND_TRIGGER=0, UART_SEND_BYTE=0. FIFO empty, overflow flag 0, both FSMs in IDLE.
- Synchronizers: AS_IN&CS_IN combined active-low strobe, and UART_SEND_BUSY_IN, each pass through 2 flops. RW/LDS/REG_ADDR/DATA_IN are stable while the strobe is low and are sampled directly.

Bus FSM (B_IDLE, B_ACK):
- B_IDLE, synced strobe low → action below, DTACK←0, go to B_ACK.
- B_ACK, synced strobe high → DTACK←1, DATA_OE←0, go to B_IDLE.
- Write to data register with LDS low:
  - Push DATA_IN if the FIFO is not full.
  - If full: byte dropped, overflow←1. DTACK is still given; the CPU is never stalled.
- Write with LDS high, or to the status register: no effect, DTACK given.
- Read of the status register:
  - DATA_OUT = {count zero-extended to 8 bits, 5'b0, overflow, full, empty}.
  - DATA_OE←1.
  - Overflow clears on the same edge.
- Read of the data register: DATA_OUT=0, DATA_OE←1.

Drain FSM (D_IDLE, D_PULSE, D_WAIT_BUSY, D_WAIT_IDLE):
- D_IDLE, FIFO non-empty and synced busy=0 → UART_SEND_BYTE←head, pop, go to D_PULSE.
- D_PULSE: trigger=1 for TRIGGER_WIDTH cycles, then trigger←0, go to D_WAIT_BUSY.
- D_WAIT_BUSY: synced busy=1 → go to D_WAIT_IDLE.
- D_WAIT_IDLE: synced busy=0 → go to D_IDLE.
- UART_SEND_BYTE holds its value until the next load.

Count and boundaries:
- Count is DEPTH_LOG2+1 bits; pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Push and pop on the same edge: both occur, count unchanged.
- The push full test uses the pre-pop count, so a push to a full FIFO is dropped even if a pop occurs that edge.
- RUN_IN low mid-transfer: immediate return to reset values; queued bytes are lost.

## Timing
- Strobe sampled low at edge n → push or read-data latch at edge n+2; DTACK low and DATA_OE high from edge n+2.
- Strobe sampled high at edge m → DTACK high and DATA_OE low from edge m+2.
- Byte pushed at edge k into an idle path (FIFO empty, busy=0):
  - load and pop at edge k+1;
  - UART_SEND_TRIGGER high at edge k+2, low at edge k+2+TRIGGER_WIDTH.
- Minimum spacing between triggers: TRIGGER_WIDTH + 4 cycles (busy round-trip through the synchronizer).

## Configuration
- UART_FIFO_BUSY_TIMEOUT_EN defined:
  - An 8-bit counter runs in D_WAIT_BUSY.
  - If 255 cycles pass without synced busy=1, go to D_IDLE. This recovers if the monitor was reset mid-handshake.
- Undefined: D_WAIT_BUSY waits indefinitely; no counter is instantiated.

## Structure
- Package monitor_uart_pkg holds:
  - bus and drain state enums;
  - status bit positions (EMPTY=0, FULL=1, OVERFLOW=2, COUNT=15:8);
  - BUSY_TIMEOUT=255.
- Sub-module uart_byte_fifo holds storage, pointers, count, full and empty.
  - Push/pop interface with a registered head.
  - Parameterised by DEPTH_LOG2.

## Test plan
- Reset: hold RUN_IN low → DTACK=1, DATA_OE=0, trigger=0, UART_SEND_BYTE=0. Status read after release returns 16'h0001.
- Single write 8'h41, busy model asserts 3 cycles after trigger rise and drops 20 cycles later:
  - exactly one trigger pulse of 2 cycles with UART_SEND_BYTE=8'h41;
  - FIFO empty afterwards.
- Burst write 8'h30..8'h3F (16 bytes) with busy held high:
  - status reads 16'h1002 (count 16, full);
  - 17th write sets overflow → status 16'h1006, next read 16'h1002.
- Release busy after the burst → 16 triggers in order 8'h30..8'h3F, each waiting for busy high→low.
- Push during a drain pop on the same edge → count unchanged, no byte lost or duplicated.
- With UART_FIFO_BUSY_TIMEOUT_EN, busy never asserts → FSM returns to D_IDLE 255 cycles after entering D_WAIT_BUSY, and the next byte is triggered.
